// File: rtl/i2s_receiver.sv
// I2S capture: oversampled bck/lrck/sdata -> {L,R} 32-bit words into a small FIFO with valid/ready output.
// Word reaches the FIFO 1 cycle after its last bit is sampled; a full FIFO drops the word and pulses overrun.
module i2s_receiver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int BCK_TIMEOUT = 255
) (
  input  logic                          in_clk,
  input  logic                          in_reset,
  input  logic                          enable,
  input  logic                          mode_22k,
  input  logic                          bck,
  input  logic                          lrck,
  input  logic                          sdata,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          bck_lost
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BCK_TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_L, CAPTURE} state_t;
  state_t state, state_nxt;

  logic          bck_s1, bck_s2, bck_s3;
  logic          lrck_s1, lrck_s2, sdata_s1, sdata_s2, lrck_prev;
  logic [5:0]    slot_cnt, slot_nxt;
  logic [15:0]   l_sr, r_sr;
  logic          l_ok, phase, wr_pend;
  logic [31:0]   frame_word;
  logic [TW-1:0] to_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          bck_rise, capturing, frame_done, rd, wr;

  assign bck_rise   = bck_s2 & ~bck_s3;
  assign capturing  = (state == CAPTURE) && bck_rise;
  assign frame_done = capturing && lrck_s2 && (slot_nxt == 6'd16) && l_ok;
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : 32'd0;
  assign fifo_level = count;
  assign rd         = out_valid & out_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign wr         = wr_pend && ((count != FULL) || rd);

  always_comb begin
    slot_nxt = 6'd0;
    if (lrck_s2 == lrck_prev)
      slot_nxt = (slot_cnt == 6'd63) ? 6'd63 : slot_cnt + 6'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !bck_lost) state_nxt = WAIT_L;
      WAIT_L:  if (bck_rise && (slot_nxt == 6'd0) && !lrck_s2) state_nxt = CAPTURE;
      default: state_nxt = state;
    endcase
    if (!enable || bck_lost) state_nxt = IDLE;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state      <= IDLE;
      bck_s1     <= 1'b0; bck_s2  <= 1'b0; bck_s3 <= 1'b0;
      lrck_s1    <= 1'b0; lrck_s2 <= 1'b0;
      sdata_s1   <= 1'b0; sdata_s2 <= 1'b0;
      lrck_prev  <= 1'b0;
      slot_cnt   <= '0;
      l_sr       <= '0;
      r_sr       <= '0;
      l_ok       <= 1'b0;
      phase      <= 1'b0;
      wr_pend    <= 1'b0;
      frame_word <= '0;
      to_cnt     <= '0;
      bck_lost   <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      bck_s1   <= bck;   bck_s2   <= bck_s1; bck_s3 <= bck_s2;
      lrck_s1  <= lrck;  lrck_s2  <= lrck_s1;
      sdata_s1 <= sdata; sdata_s2 <= sdata_s1;

      if (bck_rise) begin
        lrck_prev <= lrck_s2;
        slot_cnt  <= slot_nxt;
        if ((slot_nxt >= 6'd1) && (slot_nxt <= 6'd16)) begin
          if (lrck_s2) r_sr <= {r_sr[14:0], sdata_s2};
          else         l_sr <= {l_sr[14:0], sdata_s2};
        end
      end

      // l_ok marks a complete left half waiting for its right partner.
      if (state != CAPTURE) begin
        l_ok  <= 1'b0;
        phase <= 1'b0;
      end else if (capturing) begin
        if (!lrck_s2 && (slot_nxt == 6'd0))       l_ok <= 1'b0;
        else if (!lrck_s2 && (slot_nxt == 6'd16)) l_ok <= 1'b1;
        else if (frame_done)                      l_ok <= 1'b0;
        if (frame_done) phase <= ~phase;
      end

      wr_pend <= frame_done && (!mode_22k || !phase);
      if (frame_done) frame_word <= {l_sr, r_sr[14:0], sdata_s2};

      if (bck_rise) begin
        to_cnt   <= '0;
        bck_lost <= 1'b0;
      end else begin
        if (to_cnt != TW'(BCK_TIMEOUT)) to_cnt <= to_cnt + TW'(1);
        if (to_cnt == TW'(BCK_TIMEOUT - 1)) bck_lost <= 1'b1;
      end

      overrun <= wr_pend && !wr;
      if (wr) begin
        mem[wr_ptr] <= frame_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !rd)      count <= count + (AW+1)'(1);
      else if (rd && !wr) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: frame table driven through a bit-level I2S source, words checked via a scoreboard queue.
module tb_i2s_receiver;

  logic        in_clk = 1'b0;
  logic        in_reset, enable, mode_22k, bck, lrck, sdata, out_ready;
  logic [31:0] out_data;
  logic        out_valid, overrun, bck_lost;
  logic [2:0]  fifo_level;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ovr = 0;
  int          peak  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    int          en_from;
    logic        m22;
    logic        rdy;
    logic        kept;
  } vec_t;
  vec_t vec[15];

  i2s_receiver #(.FIFO_DEPTH(4), .BCK_TIMEOUT(255)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .enable(enable), .mode_22k(mode_22k),
    .bck(bck), .lrck(lrck), .sdata(sdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .fifo_level(fifo_level), .bck_lost(bck_lost)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted word must match the oldest expected word.
  always begin
    @(negedge in_clk);
    #1;
    if (!in_reset) begin
      if (overrun) n_ovr++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h, expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic bck_cycle(input logic l, input logic d);
    @(negedge in_clk);
    bck = 1'b0; lrck = l; sdata = d;
    repeat (3) @(negedge in_clk);
    @(negedge in_clk);
    bck = 1'b1;
    repeat (3) @(negedge in_clk);
  endtask

  // Slots j0..j1-1 of one 64-bck frame; enable is high from slot en_from on.
  task automatic send_frame(input logic [31:0] w, input int en_from, input int j0, input int j1);
    for (int j = j0; j < j1; j++) begin
      logic d;
      d = 1'b0;
      if (j >= 1 && j <= 16)  d = w[32-j];
      if (j >= 33 && j <= 48) d = w[48-j];
      enable = (j >= en_from);
      bck_cycle(j >= 32, d);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      mode_22k  = vec[i].m22;
      out_ready = vec[i].rdy;
      if (vec[i].kept) exp_q.push_back(vec[i].word);
      send_frame(vec[i].word, vec[i].en_from, 0, 64);
    end
  endtask

  initial begin
    vec[0]  = '{32'h0000_0000, 0,  1'b0, 1'b1, 1'b0};
    vec[1]  = '{32'hD999_9991, 0,  1'b0, 1'b1, 1'b1};
    vec[2]  = '{32'h9999_9993, 0,  1'b0, 1'b1, 1'b1};
    vec[3]  = '{32'h1234_5678, 64, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{32'hAAAA_0001, 0,  1'b1, 1'b1, 1'b1};
    vec[5]  = '{32'hBBBB_0002, 0,  1'b1, 1'b1, 1'b0};
    vec[6]  = '{32'hCCCC_0003, 0,  1'b1, 1'b1, 1'b1};
    vec[7]  = '{32'hDDDD_0004, 0,  1'b1, 1'b1, 1'b0};
    vec[8]  = '{32'h0000_0000, 64, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{32'h1111_1001, 0,  1'b0, 1'b0, 1'b1};
    vec[10] = '{32'h2222_2002, 0,  1'b0, 1'b0, 1'b1};
    vec[11] = '{32'h3333_3003, 0,  1'b0, 1'b0, 1'b1};
    vec[12] = '{32'h4444_4004, 0,  1'b0, 1'b0, 1'b1};
    vec[13] = '{32'h5555_5005, 0,  1'b0, 1'b0, 1'b0};
    vec[14] = '{32'h6666_6006, 0,  1'b0, 1'b0, 1'b0};

    in_reset = 1'b1; enable = 1'b0; mode_22k = 1'b0;
    bck = 1'b0; lrck = 1'b0; sdata = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge in_clk);
    #1;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   out_data,        32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_bck_lost",   32'(bck_lost),   32'd0);
    @(negedge in_clk);
    in_reset = 1'b0;

    // 44.1 kHz stream, lead-in frame has only an orphan right half
    run_rows(0, 3);
    check("ovr_44k",     32'(n_ovr),        32'd0);
    check("pending_44k", 32'(exp_q.size()), 32'd0);

    // 22.05 kHz: every other frame
    peak = 0;
    run_rows(4, 7);
    check("peak_22k",    32'(peak),         32'd1);
    check("ovr_22k",     32'(n_ovr),        32'd0);
    check("pending_22k", 32'(exp_q.size()), 32'd0);

    // Overrun with consumer stalled
    run_rows(8, 14);
    #1;
    check("level_full",  32'(fifo_level), 32'd4);
    check("ovr_count",   32'(n_ovr),      32'd2);
    out_ready = 1'b1;
    repeat (10) @(negedge in_clk);
    #1;
    check("level_drained", 32'(fifo_level),   32'd0);
    check("pending_ovr",   32'(exp_q.size()), 32'd0);

    // Enable raised mid right slot
    send_frame(32'h0, 64, 0, 64);
    send_frame(32'hEEEE_7777, 40, 0, 64);
    exp_q.push_back(32'hF00D_BEEF);
    send_frame(32'hF00D_BEEF, 0, 0, 64);
    check("pending_mid", 32'(exp_q.size()), 32'd0);

    // bck stops inside a left slot
    send_frame(32'h5A5A_A5A5, 0, 0, 11);
    repeat (200) @(negedge in_clk);
    #1;
    check("bck_lost_early", 32'(bck_lost), 32'd0);
    repeat (100) @(negedge in_clk);
    #1;
    check("bck_lost_set", 32'(bck_lost), 32'd1);
    send_frame(32'h5A5A_A5A5, 0, 11, 64);
    #1;
    check("bck_lost_clear", 32'(bck_lost), 32'd0);
    exp_q.push_back(32'h0F0F_F0F0);
    send_frame(32'h0F0F_F0F0, 0, 0, 64);
    check("pending_resume", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with three words stored
    out_ready = 1'b0;
    send_frame(32'h1357_2468, 0, 0, 64);
    send_frame(32'h2468_1357, 0, 0, 64);
    send_frame(32'hCAFE_F00D, 0, 0, 64);
    #1;
    check("level_pre_rst", 32'(fifo_level), 32'd3);
    send_frame(32'h7777_8888, 0, 0, 40);
    @(negedge in_clk);
    in_reset = 1'b1;
    @(negedge in_clk);
    in_reset = 1'b0;
    #1;
    check("rst2_level",     32'(fifo_level), 32'd0);
    check("rst2_out_valid", 32'(out_valid),  32'd0);
    check("rst2_out_data",  out_data,        32'd0);
    out_ready = 1'b1;
    repeat (20) @(negedge in_clk);
    #1;
    check("rst2_ovr",       32'(n_ovr),        32'd2);
    check("rst2_still_empty", 32'(out_valid),  32'd0);
    check("pending_final",  32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
